// File: rtl/mips_pkg.sv
// Shared MIPS definitions: FSM states, opcodes, defaults.
// Used by the MEM-stage data memory controller and its bench.
package mips_pkg;

  localparam int DATA_W_DFLT = 32;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dmem_op_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage bus between the pipeline/control unit and the
// data memory controller.
interface data_mem_ctrl_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = 32
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Stall;
  logic              Done;
  logic              AddrErr;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, Stall, Done, AddrErr
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, Stall, Done, AddrErr
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM; the read register only
// loads on re, so it holds the last load result.
module dmem_ram
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int DEPTH  = 256,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: decodes lw/sw, waits
// WAIT_CYCLES, commits to the word RAM and pulses Done.
module data_mem_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  dmem_op_e          op_q, op_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              req, reject, valid;
  logic [IW-1:0]     idx_in;
  logic              ram_we, ram_re;
  logic [IW-1:0]     ram_idx;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              stall, done;

  assign idx_in = bus.Addr[IW+1:2];
  assign req    = bus.MemRead | bus.MemWrite;

  // Misaligned, beyond the RAM, or both strobes at once.
  assign reject = req & ((bus.MemRead & bus.MemWrite)
                | (|bus.Addr[1:0])
                | ((bus.Addr >> (IW + 2)) != '0));
  assign valid  = req & ~reject;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          stall   = 1'b1;
          op_d    = bus.MemWrite ? OP_WR : OP_RD;
          idx_d   = idx_in;
          wdata_d = bus.WriteData;
          if (WAIT_CYCLES == 0) begin
            state_d   = DONE;
            ram_idx   = idx_in;
            ram_wdata = bus.WriteData;
            ram_we    = bus.MemWrite;
            ram_re    = bus.MemRead;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end else begin
          err_d = reject;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ram_we  = (op_q == OP_WR);
          ram_re  = (op_q == OP_RD);
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we & ~reset),
    .re    (ram_re & ~reset),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.ReadData = ram_rdata;
  assign bus.Stall    = stall & ~reset;
  assign bus.Done     = done;
  assign bus.AddrErr  = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: WAIT_CYCLES=2 and 0
// instances against a transaction-level reference model.
module tb_data_mem_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) m0 ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) m1 ();

  data_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (m0)
  );

  data_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (m1)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem_m [2][256];
  logic [31:0] rd_m  [2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic setin(input int sel, input bit rd,
                       input bit wr, input logic [31:0] a,
                       input logic [31:0] wd);
    if (sel == 0) begin
      m0.MemRead = rd; m0.MemWrite = wr;
      m0.Addr = a;     m0.WriteData = wd;
    end else begin
      m1.MemRead = rd; m1.MemWrite = wr;
      m1.Addr = a;     m1.WriteData = wd;
    end
  endtask

  task automatic sample(input int sel, output logic st,
                        output logic dn, output logic er,
                        output logic [31:0] rdat);
    if (sel == 0) begin
      st = m0.Stall; dn = m0.Done;
      er = m0.AddrErr; rdat = m0.ReadData;
    end else begin
      st = m1.Stall; dn = m1.Done;
      er = m1.AddrErr; rdat = m1.ReadData;
    end
  endtask

  // One full transaction; entered and left at posedge+1.
  task automatic acc(input int sel, input bit rd,
                     input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit chg);
    int w;
    int ix;
    bit rej;
    logic st, dn, er;
    logic [31:0] rdat;
    w   = (sel == 0) ? 2 : 0;
    rej = (rd && wr) || (a[1:0] != 2'b00) ||
          ((a >> 10) != 32'd0);
    ix  = int'(a[9:2]);
    setin(sel, rd, wr, a, wd);
    if (rej) begin
      @(negedge clk);
      sample(sel, st, dn, er, rdat);
      check("rej_stall", 32'(st), 32'd0);
      check("rej_done", 32'(dn), 32'd0);
      @(posedge clk); #1;
      setin(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      sample(sel, st, dn, er, rdat);
      check("rej_err", 32'(er), 32'd1);
      check("rej_done2", 32'(dn), 32'd0);
      check("rej_rdata", rdat, rd_m[sel]);
      @(posedge clk); #1;
      return;
    end
    if (wr) mem_m[sel][ix] = wd;
    else    rd_m[sel] = mem_m[sel][ix];
    for (int c = 0; c <= w + 1; c++) begin
      @(negedge clk);
      sample(sel, st, dn, er, rdat);
      check("stall", 32'(st), 32'(c <= w));
      check("done", 32'(dn), 32'(c == w + 1));
      check("err", 32'(er), 32'd0);
      if (c == w + 1) check("rdata", rdat, rd_m[sel]);
      @(posedge clk); #1;
      if (c == 0 && chg)
        setin(sel, rd, wr, a ^ 32'h4, $urandom);
    end
    setin(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle_chk(input int sel);
    logic st, dn, er;
    logic [31:0] rdat;
    @(negedge clk);
    sample(sel, st, dn, er, rdat);
    check("idle_stall", 32'(st), 32'd0);
    check("idle_done", 32'(dn), 32'd0);
    check("idle_rdata", rdat, rd_m[sel]);
    @(posedge clk); #1;
  endtask

  task automatic rand_op(input int sel);
    int mode;
    logic [5:0] opc;
    logic [31:0] a;
    mode = $urandom_range(0, 9);
    opc  = ($urandom_range(0, 1) == 1) ? LW : SW;
    a    = 32'($urandom_range(0, 255)) << 2;
    unique case (1'b1)
      (mode == 0):
        acc(sel, opc == LW, opc == SW,
            a | 32'($urandom_range(1, 3)), $urandom, 1'b0);
      (mode == 1):
        acc(sel, opc == LW, opc == SW,
            a | (32'd1 << $urandom_range(10, 31)),
            $urandom, 1'b0);
      (mode == 2):
        acc(sel, 1'b1, 1'b1, a, $urandom, 1'b0);
      default:
        acc(sel, opc == LW, opc == SW, a, $urandom, 1'b0);
    endcase
  endtask

  initial begin
    logic st, dn, er;
    logic [31:0] rdat;
    logic [31:0] va, vb;

    reset = 1'b1;
    setin(0, 1'b0, 1'b0, 32'd0, 32'd0);
    setin(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rd_m[0] = 32'd0;
    rd_m[1] = 32'd0;
    #3;
    for (int s = 0; s < 2; s++) begin
      sample(s, st, dn, er, rdat);
      check("rst_stall", 32'(st), 32'd0);
      check("rst_done", 32'(dn), 32'd0);
      check("rst_err", 32'(er), 32'd0);
      check("rst_rdata", rdat, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++)
        acc(s, 1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);

    acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    acc(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
    check("lw10", m0.ReadData, 32'hDEADBEEF);

    acc(1, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0);
    acc(1, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
    check("lw4_w0", m1.ReadData, 32'h12345678);

    for (int s = 0; s < 2; s++) begin
      acc(s, 1'b1, 1'b0, 32'h6, 32'd0, 1'b0);
      acc(s, 1'b1, 1'b0, 32'h400, 32'd0, 1'b0);
      acc(s, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 1'b0);
      idle_chk(s);
    end
    acc(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
    check("lw10_after_rej", m0.ReadData, 32'hDEADBEEF);

    // Reset lands in the first BUSY cycle of a store.
    acc(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    setin(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(posedge clk); #1;
    reset = 1'b1;
    setin(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    sample(0, st, dn, er, rdat);
    check("midrst_stall", 32'(st), 32'd0);
    check("midrst_done", 32'(dn), 32'd0);
    check("midrst_rdata", rdat, 32'd0);
    rd_m[0] = 32'd0;
    rd_m[1] = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    acc(0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    check("lw20_after_rst", m0.ReadData, 32'h0);

    va = mem_m[0][2];
    vb = mem_m[0][3];
    setin(0, 1'b1, 1'b0, 32'h8, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sample(0, st, dn, er, rdat);
      check("hold_stall", 32'(st), 32'(c % 4 != 3));
      check("hold_done", 32'(dn), 32'(c % 4 == 3));
      if (c == 3) check("hold_rd8", rdat, va);
      if (c == 7) check("hold_rdC", rdat, vb);
      @(posedge clk); #1;
      if (c == 3) setin(0, 1'b1, 1'b0, 32'hC, 32'd0);
    end
    setin(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rd_m[0] = vb;

    acc(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1);
    acc(0, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0);
    check("chg_lw30", m0.ReadData, 32'hCAFEF00D);
    acc(0, 1'b1, 1'b0, 32'h34, 32'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rand_op(0);
      rand_op(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder side of the memory-control path: consumes MemRead/MemWrite from the main control unit, plus the ALU-computed byte address and rt write data.
- Performs the access on an internal word RAM with programmable wait states.
- Stalls the pipeline while busy and returns load data with a one-cycle Done pulse.
- Sits in the MEM stage between the ALU result and the MemToReg write-back mux.

Parameters:
- DATA_W, 32, data word width (bits).
- ADDR_W, 32, byte-address width.
- DEPTH, 256, RAM depth in words; power of two.
- WAIT_CYCLES, 2, extra cycles between request accept and access commit; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemRead  input  1  load request (lw), level, from control unit.
- MemWrite  input  1  store request (sw), level, from control unit.
- Addr  input  ADDR_W  byte address (ALU result).
- WriteData  input  DATA_W  store data.
- ReadData  output  DATA_W  load data; valid when Done=1 for a read; holds until the next read completes.
- Stall  output  1  pipeline hold; high while a request is pending.
- Done  output  1  one-cycle pulse when the access commits.
- AddrErr  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (async, active-high):
  - State=IDLE, wait counter=0.
  - ReadData=0, Done=0, AddrErr=0; Stall=0 while reset is held.
  - RAM contents are not cleared.
- Valid request: exactly one of MemRead/MemWrite high while in IDLE.
- Request decode:
  - Word index = Addr[log2(DEPTH)+1:2].
  - Reject if Addr[1:0]!=0, or if any Addr bit above log2(DEPTH)+1 is nonzero, or if MemRead&MemWrite.
  - On reject: AddrErr=1 on the next cycle, no RAM access, Stall stays 0, state stays IDLE.
- Stall is combinational: high for a valid request in IDLE, and high throughout BUSY. It is low in DONE and after a reject. The pipeline holds its MEM-stage inputs stable while Stall=1.
- FSM:
  - IDLE: valid request -> latch op/index/WriteData, counter=WAIT_CYCLES; go BUSY, or go DONE if WAIT_CYCLES=0 (the commit happens on that edge).
  - BUSY: counter decrements each cycle. When counter==1 (next edge ends the wait): commit (write RAM, or register RAM[index] into ReadData) and go DONE.
  - DONE: Done=1 for exactly one cycle; requests are ignored this cycle (the pipeline advances); go IDLE.
- Latency: request first seen at edge 0 -> Done high in cycle WAIT_CYCLES+1, so the total MEM occupancy is WAIT_CYCLES+2 cycles.
- Back-to-back requests: a request held in the cycle after DONE is treated as new.
- Write-then-read of the same word returns the new data; there is no bypass need, since accesses are serialized.
- Request inputs changing during BUSY are ignored; the latched copy is used.
- ReadData is unchanged by writes and by rejects.
- Reset mid-BUSY: the access is aborted, a pending write is not committed, and the FSM returns to IDLE.
- Neither request high in IDLE: outputs idle (Stall=0, Done=0).

Decomposition:
- Shared package/header `mips_pkg`:
  - FSM state encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Opcode constants LW=6'b100011, SW=6'b101011 for bench stimulus.
  - DATA_W default.
- One natural sub-module: `dmem_ram`, a single-port synchronous word RAM (we, index, wdata, registered rdata). The FSM and counter stay in data_mem_ctrl.

Test Plan:
- Reset, then sw Addr=0x10 WriteData=0xDEADBEEF, WAIT_CYCLES=2 -> Stall high cycles 0-2, Done in cycle 3, Stall low in cycle 3; lw 0x10 -> ReadData=0xDEADBEEF with Done.
- WAIT_CYCLES=0: lw Addr=0x4 after sw 0x4 of 0x12345678 -> Done in cycle 1, ReadData=0x12345678, Stall high only in cycle 0.
- lw Addr=0x6 (misaligned), then Addr=0x400 with DEPTH=256 (out of range), then MemRead=MemWrite=1 -> AddrErr pulse each time, Stall=0, Done=0, ReadData unchanged.
- Assert reset in cycle 1 of sw Addr=0x20 data=0xA5A5A5A5 (word previously 0x0) -> after reset, lw 0x20 returns 0x0.
- Hold MemRead continuously on Addr=0x8, then 0xC -> Done pulses in cycles 3 and 7 (WAIT_CYCLES=2), with a one-cycle Stall-low gap after each Done.
- Change Addr/WriteData mid-BUSY on sw 0x30 -> the RAM word at 0x30 holds the originally latched data; the new address is untouched.
